vgc_irq_ctrl: RTL and testbench

- Interrupt status/enable block directly downstream of the PRTC clock block.
- Consumes the PRTC `onesecond_irq` and `qtrsecond_irq` pulses, plus the video timing `scanline_irq` and `vbl_irq` pulses.
- Latches them into the IIgs-visible registers: VGCINT $C023, CLRVGCINT $C032, INTEN $C041, INTFLAG $C046 and CLRVBLINT $C047.
- Drives a single level IRQ into the CPU interrupt merge.

---
 rtl/vgc_irq_ctrl_if.sv | 22 ++
 rtl/vgc_irq_ctrl.sv | 154 +++++++++++++++
 tb/tb_vgc_irq_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vgc_irq_ctrl_if.sv
// vgc_irq_ctrl_if: CPU-side $C0xx register bus for the VGC interrupt block.
// master = CPU/bus side, slave = vgc_irq_ctrl.
interface vgc_irq_ctrl_if;
  logic       cen;
  logic       io_sel;
  logic [7:0] addr;
  logic       rw;
  logic [7:0] din;
  logic       strobe;
  logic [7:0] dout;
  logic       rd_hit;

  modport master (
    output cen, io_sel, addr, rw, din, strobe,
    input  dout, rd_hit
  );

  modport slave (
    input  cen, io_sel, addr, rw, din, strobe,
    output dout, rd_hit
  );
endinterface

// File: rtl/vgc_irq_ctrl.sv
// vgc_irq_ctrl: IIgs VGC interrupt status/enable registers.
// Covers VGCINT $C023, CLRVGCINT $C032, INTEN $C041, INTFLAG $C046 and
// CLRVBLINT $C047, and merges the enabled status bits into one level irq.
// Optional build macro VGC_IRQ_OVERRUN_EN adds sticky overrun flags
// (VGCINT bits 4:3) for the one-second and scanline sources.
module vgc_irq_ctrl #(
  parameter logic [7:0] ADDR_VGCINT  = 8'h23,
  parameter logic [7:0] ADDR_CLRVGC  = 8'h32,
  parameter logic [7:0] ADDR_INTEN   = 8'h41,
  parameter logic [7:0] ADDR_INTFLAG = 8'h46,
  parameter logic [7:0] ADDR_CLRVBL  = 8'h47
) (
  input  logic            CLK_14M,
  input  logic            reset,
  vgc_irq_ctrl_if.slave   bus,
  input  logic            onesecond_irq,
  input  logic            qtrsecond_irq,
  input  logic            scanline_irq,
  input  logic            vbl_irq,
  output logic            irq
);

  logic       en1s_q, en1s_d, enscan_q, enscan_d;
  logic       enqtr_q, enqtr_d, envbl_q, envbl_d;
  logic [2:0] mouse_en_q, mouse_en_d;
  logic       st1s_q, st1s_d, stscan_q, stscan_d;
  logic       stqtr_q, stqtr_d, stvbl_q, stvbl_d;
  logic [7:0] dout_q, dout_d;
  logic       rd_hit_q, rd_hit_d;
  logic       irq_q, irq_d;

  logic       commit, wr;
  logic       clr_1s, clr_scan, clr_vbl;
  logic [1:0] ov_rd;
  logic [7:0] vgcint_rd;
  logic       unused_din7;

  assign unused_din7 = bus.din[7];

`ifdef VGC_IRQ_OVERRUN_EN
  logic ov1s_q, ov1s_d, ovscan_q, ovscan_d;

  // Overrun flags: an enabled event landing on an already-set status bit
  always_comb begin
    ov1s_d   = (ov1s_q & ~clr_1s) | (onesecond_irq & en1s_q & st1s_q);
    ovscan_d = (ovscan_q & ~clr_scan) | (scanline_irq & enscan_q & stscan_q);
    ov_rd    = {ov1s_q, ovscan_q};
  end

  // Overrun flag registers
  always_ff @(posedge CLK_14M) begin
    if (reset) begin
      ov1s_q   <= 1'b0;
      ovscan_q <= 1'b0;
    end else begin
      ov1s_q   <= ov1s_d;
      ovscan_q <= ovscan_d;
    end
  end
`else
  assign ov_rd = 2'b00;
`endif

  // Bus decode, enable/status next-state, read mux and irq merge
  always_comb begin
    commit   = bus.io_sel & bus.strobe & bus.cen;
    wr       = commit & ~bus.rw;
    clr_1s   = wr & (bus.addr == ADDR_CLRVGC) & ~bus.din[6];
    clr_scan = wr & (bus.addr == ADDR_CLRVGC) & ~bus.din[5];
    clr_vbl  = commit & (bus.addr == ADDR_CLRVBL);

    en1s_d     = en1s_q;
    enscan_d   = enscan_q;
    enqtr_d    = enqtr_q;
    envbl_d    = envbl_q;
    mouse_en_d = mouse_en_q;
    if (wr && bus.addr == ADDR_VGCINT) begin
      en1s_d   = bus.din[2];
      enscan_d = bus.din[1];
    end
    if (wr && bus.addr == ADDR_INTEN) begin
      enqtr_d    = bus.din[4];
      envbl_d    = bus.din[3];
      mouse_en_d = bus.din[2:0];
    end

    // Sets are ORed in after clears so a same-cycle event is never lost
    st1s_d   = (st1s_q & ~clr_1s) | (onesecond_irq & en1s_q);
    stscan_d = (stscan_q & ~clr_scan) | (scanline_irq & enscan_q);
    stqtr_d  = (stqtr_q & ~clr_vbl) | (qtrsecond_irq & enqtr_q);
    stvbl_d  = (stvbl_q & ~clr_vbl) | (vbl_irq & envbl_q);

    vgcint_rd = {(st1s_q & en1s_q) | (stscan_q & enscan_q), st1s_q, stscan_q,
                 ov_rd, en1s_q, enscan_q, 1'b0};

    dout_d   = dout_q;
    rd_hit_d = rd_hit_q;
    if (bus.io_sel && bus.rw) begin
      dout_d   = 8'h00;
      rd_hit_d = 1'b0;
      if (bus.addr == ADDR_VGCINT) begin
        dout_d   = vgcint_rd;
        rd_hit_d = 1'b1;
      end else if (bus.addr == ADDR_INTEN) begin
        dout_d   = {3'b000, enqtr_q, envbl_q, mouse_en_q};
        rd_hit_d = 1'b1;
      end else if (bus.addr == ADDR_INTFLAG) begin
        dout_d   = {3'b000, stqtr_q, stvbl_q, 3'b000};
        rd_hit_d = 1'b1;
      end else if (bus.addr == ADDR_CLRVBL) begin
        rd_hit_d = 1'b1;
      end
    end

    irq_d = (st1s_q & en1s_q) | (stscan_q & enscan_q) |
            (stqtr_q & enqtr_q) | (stvbl_q & envbl_q);
  end

  // State, read data and irq registers
  always_ff @(posedge CLK_14M) begin
    if (reset) begin
      en1s_q     <= 1'b0;
      enscan_q   <= 1'b0;
      enqtr_q    <= 1'b0;
      envbl_q    <= 1'b0;
      mouse_en_q <= 3'b000;
      st1s_q     <= 1'b0;
      stscan_q   <= 1'b0;
      stqtr_q    <= 1'b0;
      stvbl_q    <= 1'b0;
      dout_q     <= 8'h00;
      rd_hit_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      en1s_q     <= en1s_d;
      enscan_q   <= enscan_d;
      enqtr_q    <= enqtr_d;
      envbl_q    <= envbl_d;
      mouse_en_q <= mouse_en_d;
      st1s_q     <= st1s_d;
      stscan_q   <= stscan_d;
      stqtr_q    <= stqtr_d;
      stvbl_q    <= stvbl_d;
      dout_q     <= dout_d;
      rd_hit_q   <= rd_hit_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.dout   = dout_q;
  assign bus.rd_hit = rd_hit_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_vgc_irq_ctrl.sv
// tb_vgc_irq_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic checked against a rule-level register model.
module tb_vgc_irq_ctrl;

  logic CLK_14M = 1'b0;
  logic reset;
  logic onesecond_irq, qtrsecond_irq, scanline_irq, vbl_irq;
  logic irq;

  vgc_irq_ctrl_if bus_if ();

  vgc_irq_ctrl dut (
    .CLK_14M       (CLK_14M),
    .reset         (reset),
    .bus           (bus_if.slave),
    .onesecond_irq (onesecond_irq),
    .qtrsecond_irq (qtrsecond_irq),
    .scanline_irq  (scanline_irq),
    .vbl_irq       (vbl_irq),
    .irq           (irq)
  );

  always #5 CLK_14M = ~CLK_14M;

  int passCount  = 0;
  int checkCount = 0;

  // ev bits: {onesecond, qtrsecond, scanline, vbl}
  typedef struct {
    logic       sel;
    logic       cen;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] din;
    logic [3:0] ev;
    logic       chkDout;
    logic [7:0] expDout;
    logic       expHit;
    logic       expIrq;
  } vec_t;

  vec_t vecs[$];

  // Rule-level model of the visible registers
  bit mEn1s, mEnscan, mEnqtr, mEnvbl;
  bit [2:0] mMouse;
  bit mSt1s, mStscan, mStqtr, mStvbl, mOv1s, mOvscan;
  bit [7:0] mDout;
  bit mHit, mIrq;
  bit modelOn = 0;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checkCount++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input logic sel, input logic cen, input logic rw,
                               input logic [7:0] addr, input logic [7:0] din,
                               input logic [3:0] ev, input logic rst);
    reset          = rst;
    bus_if.io_sel  = sel;
    bus_if.cen     = cen;
    bus_if.strobe  = sel;
    bus_if.rw      = rw;
    bus_if.addr    = addr;
    bus_if.din     = din;
    onesecond_irq  = ev[3];
    qtrsecond_irq  = ev[2];
    scanline_irq   = ev[1];
    vbl_irq        = ev[0];
  endtask

  function automatic bit [7:0] modelRead(input bit [7:0] a, output bit hit);
    bit ovA, ovB;
    hit = 1;
`ifdef VGC_IRQ_OVERRUN_EN
    ovA = mOv1s; ovB = mOvscan;
`else
    ovA = 0; ovB = 0;
`endif
    case (a)
      8'h23: return {(mSt1s && mEn1s) || (mStscan && mEnscan), mSt1s, mStscan,
                     ovA, ovB, mEn1s, mEnscan, 1'b0};
      8'h41: return {3'b000, mEnqtr, mEnvbl, mMouse};
      8'h46: return {3'b000, mStqtr, mStvbl, 3'b000};
      8'h47: return 8'h00;
      default: begin hit = 0; return 8'h00; end
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently driven
  task automatic modelStep();
    bit commit, wr, h;
    bit [7:0] d, a, rv;
    bit n1s, nscan, nqtr, nvbl, no1s, noscan;
    if (reset) begin
      {mEn1s, mEnscan, mEnqtr, mEnvbl, mMouse} = '0;
      {mSt1s, mStscan, mStqtr, mStvbl, mOv1s, mOvscan} = '0;
      mDout = 0; mHit = 0; mIrq = 0;
      return;
    end
    a = bus_if.addr; d = bus_if.din;
    commit = bus_if.io_sel && bus_if.strobe && bus_if.cen;
    wr = commit && !bus_if.rw;
    if (bus_if.io_sel && bus_if.rw) begin
      rv = modelRead(a, h);
      mDout = rv; mHit = h;
    end
    mIrq = (mSt1s && mEn1s) || (mStscan && mEnscan) || (mStqtr && mEnqtr) || (mStvbl && mEnvbl);
    n1s = mSt1s; nscan = mStscan; nqtr = mStqtr; nvbl = mStvbl;
    no1s = mOv1s; noscan = mOvscan;
    if (wr && a == 8'h32 && !d[6]) begin n1s = 0; no1s = 0; end
    if (wr && a == 8'h32 && !d[5]) begin nscan = 0; noscan = 0; end
    if (commit && a == 8'h47) begin nqtr = 0; nvbl = 0; end
    if (onesecond_irq && mEn1s) begin
      if (mSt1s) no1s = 1;
      n1s = 1;
    end
    if (scanline_irq && mEnscan) begin
      if (mStscan) noscan = 1;
      nscan = 1;
    end
    if (qtrsecond_irq && mEnqtr) nqtr = 1;
    if (vbl_irq && mEnvbl) nvbl = 1;
    if (wr && a == 8'h23) begin mEn1s = d[2]; mEnscan = d[1]; end
    if (wr && a == 8'h41) begin mEnqtr = d[4]; mEnvbl = d[3]; mMouse = d[2:0]; end
    mSt1s = n1s; mStscan = nscan; mStqtr = nqtr; mStvbl = nvbl;
    mOv1s = no1s; mOvscan = noscan;
  endtask

  task automatic tick();
    if (modelOn) modelStep();
    @(posedge CLK_14M);
    #1;
  endtask

  // One bus cycle with cen=1; returns after the edge has been taken
  task automatic cyc(input logic sel, input logic rw, input logic [7:0] addr,
                     input logic [7:0] din, input logic [3:0] ev);
    applyStimulus(sel, 1'b1, rw, addr, din, ev, 1'b0);
    tick();
  endtask

  task automatic addVec(input logic sel, input logic cen, input logic rw,
                        input logic [7:0] addr, input logic [7:0] din,
                        input logic [3:0] ev, input logic chk,
                        input logic [7:0] eDout, input logic eHit, input logic eIrq);
    vec_t v;
    v.sel = sel; v.cen = cen; v.rw = rw; v.addr = addr; v.din = din; v.ev = ev;
    v.chkDout = chk; v.expDout = eDout; v.expHit = eHit; v.expIrq = eIrq;
    vecs.push_back(v);
  endtask

  initial begin
    bit [7:0] pick[5];
    bit [7:0] a;
    pick[0] = 8'h23; pick[1] = 8'h32; pick[2] = 8'h41; pick[3] = 8'h46; pick[4] = 8'h47;

    //      sel cen rw  addr   din    ev      chk dout   hit irq
    addVec(1, 1, 1, 8'h23, 8'h00, 4'b0000, 1, 8'h00, 1, 0);
    addVec(1, 1, 1, 8'h41, 8'h00, 4'b0000, 1, 8'h00, 1, 0);
    addVec(1, 1, 1, 8'h46, 8'h00, 4'b0000, 1, 8'h00, 1, 0);
    addVec(1, 1, 0, 8'h23, 8'h04, 4'b0000, 0, 8'h00, 0, 0);
    addVec(0, 1, 1, 8'h00, 8'h00, 4'b1000, 0, 8'h00, 0, 0);
    addVec(0, 1, 1, 8'h00, 8'h00, 4'b0000, 0, 8'h00, 0, 1);
    addVec(1, 1, 1, 8'h23, 8'h00, 4'b0000, 1, 8'hC4, 1, 1);
    addVec(1, 1, 0, 8'h32, 8'hBF, 4'b0000, 0, 8'h00, 0, 1);
    addVec(0, 1, 1, 8'h00, 8'h00, 4'b0000, 0, 8'h00, 0, 0);
    addVec(1, 1, 1, 8'h23, 8'h00, 4'b0000, 1, 8'h04, 1, 0);
    addVec(1, 1, 0, 8'h23, 8'h00, 4'b0000, 0, 8'h00, 0, 0);
    addVec(0, 1, 1, 8'h00, 8'h00, 4'b1000, 0, 8'h00, 0, 0);
    addVec(0, 1, 1, 8'h00, 8'h00, 4'b0000, 0, 8'h00, 0, 0);
    addVec(1, 1, 1, 8'h23, 8'h00, 4'b0000, 1, 8'h00, 1, 0);
    addVec(1, 1, 0, 8'h41, 8'h18, 4'b0000, 0, 8'h00, 0, 0);
    addVec(0, 1, 1, 8'h00, 8'h00, 4'b0101, 0, 8'h00, 0, 0);
    addVec(0, 1, 1, 8'h00, 8'h00, 4'b0000, 0, 8'h00, 0, 1);
    addVec(1, 1, 1, 8'h46, 8'h00, 4'b0000, 1, 8'h18, 1, 1);
    addVec(1, 1, 1, 8'h47, 8'h00, 4'b0000, 1, 8'h00, 1, 1);
    addVec(1, 1, 1, 8'h46, 8'h00, 4'b0000, 1, 8'h00, 1, 0);
    addVec(1, 1, 1, 8'h47, 8'h00, 4'b0100, 1, 8'h00, 1, 0);
    addVec(0, 1, 1, 8'h00, 8'h00, 4'b0000, 0, 8'h00, 0, 1);
    addVec(1, 1, 1, 8'h46, 8'h00, 4'b0000, 1, 8'h10, 1, 1);
    addVec(1, 1, 1, 8'h32, 8'h00, 4'b0000, 1, 8'h00, 0, 1);
    addVec(1, 1, 1, 8'h55, 8'h00, 4'b0000, 1, 8'h00, 0, 1);
    addVec(1, 1, 1, 8'h47, 8'h00, 4'b0000, 1, 8'h00, 1, 1);
    addVec(0, 1, 1, 8'h00, 8'h00, 4'b0000, 0, 8'h00, 0, 0);
    addVec(1, 1, 0, 8'h23, 8'h02, 4'b0000, 0, 8'h00, 0, 0);
    addVec(0, 1, 1, 8'h00, 8'h00, 4'b0010, 0, 8'h00, 0, 0);
    addVec(1, 1, 1, 8'h23, 8'h00, 4'b0000, 1, 8'hA2, 1, 1);
    addVec(1, 1, 0, 8'h32, 8'hDF, 4'b0000, 0, 8'h00, 0, 1);
    addVec(1, 1, 1, 8'h23, 8'h00, 4'b0000, 1, 8'h02, 1, 0);
    addVec(1, 0, 0, 8'h23, 8'h04, 4'b0000, 0, 8'h00, 0, 0);
    addVec(1, 1, 1, 8'h23, 8'h00, 4'b0000, 1, 8'h02, 1, 0);
    addVec(1, 1, 1, 8'h41, 8'h00, 4'b0000, 1, 8'h18, 1, 0);

    applyStimulus(0, 0, 1, 8'h00, 8'h00, 4'b0000, 1'b1);
    tick(); tick();
    checkOutput("reset_dout", bus_if.dout, 8'h00);
    checkOutput("reset_rd_hit", {7'd0, bus_if.rd_hit}, 8'h00);
    checkOutput("reset_irq", {7'd0, irq}, 8'h00);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sel, vecs[i].cen, vecs[i].rw, vecs[i].addr,
                    vecs[i].din, vecs[i].ev, 1'b0);
      tick();
      if (vecs[i].chkDout) begin
        checkOutput($sformatf("vec%0d_dout", i), bus_if.dout, vecs[i].expDout);
        checkOutput($sformatf("vec%0d_rd_hit", i), {7'd0, bus_if.rd_hit}, {7'd0, vecs[i].expHit});
      end
      checkOutput($sformatf("vec%0d_irq", i), {7'd0, irq}, {7'd0, vecs[i].expIrq});
    end

    // Two one-second events without a clear: overrun flag when built in
    cyc(1, 0, 8'h23, 8'h04, 4'b0000);
    cyc(0, 1, 8'h00, 8'h00, 4'b1000);
    cyc(0, 1, 8'h00, 8'h00, 4'b0000);
    cyc(0, 1, 8'h00, 8'h00, 4'b1000);
    cyc(1, 1, 8'h23, 8'h00, 4'b0000);
`ifdef VGC_IRQ_OVERRUN_EN
    checkOutput("overrun_set", bus_if.dout, 8'hD4);
`else
    checkOutput("overrun_absent", bus_if.dout, 8'hC4);
`endif
    checkOutput("overrun_irq", {7'd0, irq}, 8'h01);
    cyc(1, 0, 8'h32, 8'hBF, 4'b0000);
    cyc(1, 1, 8'h23, 8'h00, 4'b0000);
    checkOutput("overrun_clear", bus_if.dout, 8'h04);
    checkOutput("overrun_clear_irq", {7'd0, irq}, 8'h00);

    // Reset asserted during a committed write discards the write
    applyStimulus(1, 1, 0, 8'h41, 8'h1F, 4'b0000, 1'b1);
    tick();
    cyc(1, 1, 8'h41, 8'h00, 4'b0000);
    checkOutput("reset_mid_access", bus_if.dout, 8'h00);
    cyc(1, 1, 8'h23, 8'h00, 4'b0000);
    checkOutput("reset_clears_en", bus_if.dout, 8'h00);

    // Randomized traffic against the model
    applyStimulus(0, 0, 1, 8'h00, 8'h00, 4'b0000, 1'b1);
    modelOn = 1;
    tick();
    for (int n = 0; n < 3000; n++) begin
      a = ($urandom_range(0, 7) < 6) ? pick[$urandom_range(0, 4)] : 8'($urandom);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1, a, 8'($urandom),
                    {$urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0},
                    $urandom_range(0, 299) == 0);
      bus_if.strobe = bus_if.io_sel & ($urandom_range(0, 3) != 0);
      tick();
      checkOutput("rand_dout", bus_if.dout, mDout);
      checkOutput("rand_rd_hit", {7'd0, bus_if.rd_hit}, {7'd0, mHit});
      checkOutput("rand_irq", {7'd0, irq}, {7'd0, mIrq});
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
